// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet pool: directions, map encoding,
// sweep FSM states and the per-slot record.
package bullet_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam logic [1:0] TILE_EMPTY = 2'd0;
    localparam int         TANK_SIZE  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESOLVE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       owner;
        logic [7:0] x;
        logic [7:0] y;
        dir_t       dir;
    } slot_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        dir_t       dir;
    } spawn_t;

    // One axis of motion in 9-bit signed space so walking off the left/top edge goes negative.
    function automatic logic signed [8:0] step_axis(input logic [7:0] p, input logic dec,
                                                    input logic inc, input logic signed [8:0] speed);
        return $signed({1'b0, p}) + (inc ? speed : 9'sd0) - (dec ? speed : 9'sd0);
    endfunction

endpackage

// File: rtl/bullet_hit_test.sv
// Combinational point-in-box test of a candidate bullet position against one
// tank's TANK_SIZE x TANK_SIZE footprint.
module bullet_hit_test
    import bullet_pkg::*;
(
    input  logic signed [8:0] i_nx,
    input  logic signed [8:0] i_ny,
    input  logic [7:0]        i_tank_x,
    input  logic [7:0]        i_tank_y,
    input  logic              i_alive,
    output logic              o_hit
);

    localparam logic [9:0] SZ = 10'(TANK_SIZE);

    logic [9:0] w_px, w_py, w_tx, w_ty;

    // Widened so tank_x + 8 cannot wrap near the right edge.
    assign w_px = {1'b0, i_nx};
    assign w_py = {1'b0, i_ny};
    assign w_tx = {2'b00, i_tank_x};
    assign w_ty = {2'b00, i_tank_y};

    assign o_hit = i_alive && !i_nx[8] && !i_ny[8]
                && (w_px >= w_tx) && (w_px < w_tx + SZ)
                && (w_py >= w_ty) && (w_py < w_ty + SZ);

endmodule

// File: rtl/bullet_engine.sv
// Shared bullet pool: spawns from both tanks, one ISSUE/WAIT/RESOLVE pass per
// slot on each game_tick, wall queries to the tile map and per-tank hit pulses.
module bullet_engine
    import bullet_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SPEED     = 2,
    parameter int MAX_X     = 199,
    parameter int MAX_Y     = 143
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   game_tick,
    input  logic                   fire_a,
    input  logic                   fire_b,
    input  logic [7:0]             start_xa,
    input  logic [7:0]             start_ya,
    input  logic [7:0]             start_xb,
    input  logic [7:0]             start_yb,
    input  logic [1:0]             dir_a,
    input  logic [1:0]             dir_b,
    input  logic [7:0]             tank_xa,
    input  logic [7:0]             tank_ya,
    input  logic [7:0]             tank_xb,
    input  logic [7:0]             tank_yb,
    input  logic                   alive_a,
    input  logic                   alive_b,
    output logic [4:0]             tile_x,
    output logic [4:0]             tile_y,
    input  logic [1:0]             tile_type,
    output logic                   hit_a,
    output logic                   hit_b,
    output logic                   busy,
    output logic [NUM_SLOTS-1:0]   bullet_valid,
    output logic [8*NUM_SLOTS-1:0] bullet_x,
    output logic [8*NUM_SLOTS-1:0] bullet_y
);

    localparam int                IW       = $clog2(NUM_SLOTS);
    localparam logic [IW-1:0]     LAST_IDX = IW'(NUM_SLOTS - 1);
    localparam logic signed [8:0] SPEED9   = 9'(SPEED);
    localparam logic signed [8:0] MAX_X9   = 9'(MAX_X);
    localparam logic signed [8:0] MAX_Y9   = 9'(MAX_Y);

    state_t            r_state, w_state_next;
    slot_t             r_slots [NUM_SLOTS];
    logic [IW-1:0]     r_idx;
    logic              r_pend_a, r_pend_b, r_tick_pend;
    spawn_t            r_spawn_a, r_spawn_b;
    logic signed [8:0] r_nx, r_ny;
    logic [4:0]        r_tile_x, r_tile_y;
    logic              r_hit_a, r_hit_b;

    slot_t             w_cur;
    logic signed [8:0] w_nx, w_ny;
    logic              w_free_found;
    logic [IW-1:0]     w_free_idx;
    logic              w_can_serve, w_serve_a, w_serve_b;
    logic              w_oob, w_wall, w_box_a, w_box_b, w_resolve, w_kill_a, w_kill_b;

    assign w_cur = r_slots[r_idx];
    assign w_nx  = step_axis(w_cur.x, w_cur.dir == DIR_LEFT, w_cur.dir == DIR_RIGHT, SPEED9);
    assign w_ny  = step_axis(w_cur.y, w_cur.dir == DIR_UP,   w_cur.dir == DIR_DOWN,  SPEED9);

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_slots[i].valid) begin
                w_free_found = 1'b1;
                w_free_idx   = IW'(i);
            end
        end
    end

    // Spawns never overlap a sweep, so slot writes from both paths cannot collide.
    assign w_can_serve = (r_state == ST_IDLE) && !game_tick && !r_tick_pend;
    assign w_serve_a   = w_can_serve && r_pend_a;
    assign w_serve_b   = w_can_serve && !r_pend_a && r_pend_b;

    bullet_hit_test u_hit_a (
        .i_nx(r_nx), .i_ny(r_ny), .i_tank_x(tank_xa), .i_tank_y(tank_ya),
        .i_alive(alive_a), .o_hit(w_box_a)
    );

    bullet_hit_test u_hit_b (
        .i_nx(r_nx), .i_ny(r_ny), .i_tank_x(tank_xb), .i_tank_y(tank_yb),
        .i_alive(alive_b), .o_hit(w_box_b)
    );

    assign w_oob     = r_nx[8] || r_ny[8] || (r_nx > MAX_X9) || (r_ny > MAX_Y9);
    assign w_wall    = (tile_type != TILE_EMPTY);
    assign w_resolve = (r_state == ST_RESOLVE) && w_cur.valid;
    assign w_kill_a  = w_resolve && !w_oob && !w_wall &&  w_cur.owner && w_box_a;
    assign w_kill_b  = w_resolve && !w_oob && !w_wall && !w_cur.owner && w_box_b;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (game_tick || r_tick_pend) w_state_next = ST_ISSUE;
            ST_ISSUE:   w_state_next = ST_WAIT;
            ST_WAIT:    w_state_next = ST_RESOLVE;
            ST_RESOLVE: w_state_next = (r_idx == LAST_IDX) ? ST_DONE : ST_ISSUE;
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) r_slots[i] <= '0;
            r_idx       <= '0;
            r_pend_a    <= 1'b0;
            r_pend_b    <= 1'b0;
            r_tick_pend <= 1'b0;
            r_spawn_a   <= '0;
            r_spawn_b   <= '0;
            r_nx        <= '0;
            r_ny        <= '0;
            r_tile_x    <= '0;
            r_tile_y    <= '0;
            r_hit_a     <= 1'b0;
            r_hit_b     <= 1'b0;
        end else begin
            r_hit_a <= w_kill_a;
            r_hit_b <= w_kill_b;

            // A fresh pulse beats the clear so a request landing on its own service cycle survives.
            if (fire_a) begin
                r_pend_a  <= 1'b1;
                r_spawn_a <= '{x: start_xa, y: start_ya, dir: dir_t'(dir_a)};
            end else if (w_serve_a) begin
                r_pend_a  <= 1'b0;
            end
            if (fire_b) begin
                r_pend_b  <= 1'b1;
                r_spawn_b <= '{x: start_xb, y: start_yb, dir: dir_t'(dir_b)};
            end else if (w_serve_b) begin
                r_pend_b  <= 1'b0;
            end

            if (w_serve_a && w_free_found)
                r_slots[w_free_idx] <= '{valid: 1'b1, owner: 1'b0, x: r_spawn_a.x,
                                         y: r_spawn_a.y, dir: r_spawn_a.dir};
            else if (w_serve_b && w_free_found)
                r_slots[w_free_idx] <= '{valid: 1'b1, owner: 1'b1, x: r_spawn_b.x,
                                         y: r_spawn_b.y, dir: r_spawn_b.dir};

            if (r_state == ST_IDLE) r_tick_pend <= 1'b0;
            else if (game_tick)     r_tick_pend <= 1'b1;

            case (r_state)
                ST_IDLE: r_idx <= '0;
                ST_ISSUE: begin
                    r_nx     <= w_nx;
                    r_ny     <= w_ny;
                    r_tile_x <= w_nx[7:3];
                    r_tile_y <= w_ny[7:3];
                end
                ST_RESOLVE: begin
                    if (w_cur.valid) begin
                        if (w_oob || w_wall || w_kill_a || w_kill_b) begin
                            r_slots[r_idx].valid <= 1'b0;
                        end else begin
                            r_slots[r_idx].x <= r_nx[7:0];
                            r_slots[r_idx].y <= r_ny[7:0];
                        end
                    end
                    r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign hit_a  = r_hit_a;
    assign hit_b  = r_hit_b;
    assign tile_x = r_tile_x;
    assign tile_y = r_tile_y;

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_out
        assign bullet_valid[gi]     = r_slots[gi].valid;
        assign bullet_x[8*gi +: 8]  = r_slots[gi].x;
        assign bullet_y[8*gi +: 8]  = r_slots[gi].y;
    end

endmodule

// File: tb/tb_bullet_engine.sv
// Scoreboard bench for bullet_engine: a slot-list model predicts each sweep's
// result, a monitor compares whenever a sweep ends (busy falls).
module tb_bullet_engine;

    localparam int NS    = 4;
    localparam int SPEED = 2;
    localparam int MAX_X = 199;
    localparam int MAX_Y = 143;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic game_tick = 1'b0, fire_a = 1'b0, fire_b = 1'b0;
    logic [7:0] start_xa = '0, start_ya = '0, start_xb = '0, start_yb = '0;
    logic [1:0] dir_a = '0, dir_b = '0;
    logic [7:0] tank_xa = '0, tank_ya = '0, tank_xb = '0, tank_yb = '0;
    logic alive_a = 1'b0, alive_b = 1'b0;
    logic [4:0] tile_x, tile_y;
    logic [1:0] tile_type = '0;
    logic hit_a, hit_b, busy;
    logic [NS-1:0]   bullet_valid;
    logic [8*NS-1:0] bullet_x, bullet_y;

    always #5 clk = ~clk;

    bullet_engine #(.NUM_SLOTS(NS), .SPEED(SPEED), .MAX_X(MAX_X), .MAX_Y(MAX_Y)) dut (
        .clk(clk), .rst(rst), .game_tick(game_tick),
        .fire_a(fire_a), .fire_b(fire_b),
        .start_xa(start_xa), .start_ya(start_ya), .start_xb(start_xb), .start_yb(start_yb),
        .dir_a(dir_a), .dir_b(dir_b),
        .tank_xa(tank_xa), .tank_ya(tank_ya), .tank_xb(tank_xb), .tank_yb(tank_yb),
        .alive_a(alive_a), .alive_b(alive_b),
        .tile_x(tile_x), .tile_y(tile_y), .tile_type(tile_type),
        .hit_a(hit_a), .hit_b(hit_b), .busy(busy),
        .bullet_valid(bullet_valid), .bullet_x(bullet_x), .bullet_y(bullet_y)
    );

    // Tile map environment: answers the registered query one cycle later.
    logic [1:0] m_map [0:31][0:31];
    always @(posedge clk) begin
        #1;
        tile_type = m_map[tile_y][tile_x];
    end

    typedef struct packed {
        logic [3:0]  v;
        logic [31:0] xs;
        logic [31:0] ys;
        logic [7:0]  ha;
        logic [7:0]  hb;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference bullet list
    int m_v[NS], m_own[NS], m_x[NS], m_y[NS], m_d[NS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [3:0] m_mask();
        logic [3:0] r = '0;
        for (int i = 0; i < NS; i++) r[i] = (m_v[i] != 0);
        return r;
    endfunction

    function automatic logic [31:0] pos_mask(input logic [3:0] v);
        logic [31:0] r = '0;
        for (int i = 0; i < NS; i++) if (v[i]) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [31:0] m_xs();
        logic [31:0] r = '0;
        for (int i = 0; i < NS; i++) r[8*i +: 8] = 8'(m_x[i]);
        return r;
    endfunction

    function automatic logic [31:0] m_ys();
        logic [31:0] r = '0;
        for (int i = 0; i < NS; i++) r[8*i +: 8] = 8'(m_y[i]);
        return r;
    endfunction

    function automatic bit in_box(input int px, input int py, input int tx, input int ty);
        return (px >= tx) && (px < tx + 8) && (py >= ty) && (py < ty + 8);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NS; i++) m_v[i] = 0;
    endtask

    task automatic map_clear();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) m_map[r][c] = 2'd0;
    endtask

    task automatic model_spawn(input int own, input int x, input int y, input int d);
        bit done = 0;
        for (int i = 0; i < NS; i++) begin
            if (!done && m_v[i] == 0) begin
                m_v[i] = 1; m_own[i] = own; m_x[i] = x; m_y[i] = y; m_d[i] = d;
                done = 1;
            end
        end
    endtask

    task automatic model_sweep();
        exp_t e;
        int nx, ny;
        e = '0;
        for (int i = 0; i < NS; i++) begin
            if (m_v[i] != 0) begin
                nx = m_x[i]; ny = m_y[i];
                case (m_d[i])
                    0: ny = ny - SPEED;
                    1: ny = ny + SPEED;
                    2: nx = nx - SPEED;
                    default: nx = nx + SPEED;
                endcase
                if (nx < 0 || nx > MAX_X || ny < 0 || ny > MAX_Y) m_v[i] = 0;
                else if (m_map[ny/8][nx/8] != 2'd0) m_v[i] = 0;
                else if (m_own[i] == 0 && alive_b && in_box(nx, ny, tank_xb, tank_yb)) begin
                    m_v[i] = 0; e.hb = e.hb + 8'd1;
                end else if (m_own[i] == 1 && alive_a && in_box(nx, ny, tank_xa, tank_ya)) begin
                    m_v[i] = 0; e.ha = e.ha + 8'd1;
                end else begin
                    m_x[i] = nx; m_y[i] = ny;
                end
            end
        end
        e.v = m_mask(); e.xs = m_xs(); e.ys = m_ys();
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison set per completed sweep
    int busy_cnt = 0, ha_cnt = 0, hb_cnt = 0;
    bit prev_busy = 0, aborted = 0;
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] pm;
        if (busy) begin
            busy_cnt++;
            if (rst) aborted = 1;
        end
        if (hit_a) ha_cnt++;
        if (hit_b) hb_cnt++;
        if (prev_busy && !busy) begin
            if (!aborted) begin
                if (exp_q.size() == 0) begin
                    chk("sweep_unexpected", 64'(busy_cnt), 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    pm = pos_mask(e.v);
                    chk("sweep_len", 64'(busy_cnt), 64'(3*NS+1));
                    chk("sweep_valid", 64'(bullet_valid), 64'(e.v));
                    chk("sweep_x", 64'(bullet_x & pm), 64'(e.xs & pm));
                    chk("sweep_y", 64'(bullet_y & pm), 64'(e.ys & pm));
                    chk("sweep_hit_a", 64'(ha_cnt), 64'(e.ha));
                    chk("sweep_hit_b", 64'(hb_cnt), 64'(e.hb));
                    $display("sweep done: valid=%b hit_a=%0d hit_b=%0d", bullet_valid, ha_cnt, hb_cnt);
                end
            end
            busy_cnt = 0; ha_cnt = 0; hb_cnt = 0; aborted = 0;
        end
        prev_busy = busy;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        model_clear();
        map_clear();
    endtask

    task automatic fire(input bit a, input bit b, input int xa, input int ya, input int da,
                        input int xb, input int yb, input int db);
        logic [3:0] m0, m1, m2;
        cyc(1);
        m0 = m_mask();
        fire_a = a; fire_b = b;
        start_xa = 8'(xa); start_ya = 8'(ya); dir_a = 2'(da);
        start_xb = 8'(xb); start_yb = 8'(yb); dir_b = 2'(db);
        if (a) model_spawn(0, xa, ya, da);
        m1 = m_mask();
        if (b) model_spawn(1, xb, yb, db);
        m2 = m_mask();
        if (!a) m1 = m2;
        $display("fire a=%0d (%0d,%0d,%0d) b=%0d (%0d,%0d,%0d) -> expect valid %b", a, xa, ya, da, b, xb, yb, db, m2);
        cyc(1);
        fire_a = 1'b0; fire_b = 1'b0;
        @(negedge clk) chk("spawn_latch", 64'(bullet_valid), 64'(m0));
        cyc(1);
        @(negedge clk) chk("spawn_first", 64'(bullet_valid), 64'(m1));
        cyc(1);
        @(negedge clk) begin
            chk("spawn_second", 64'(bullet_valid), 64'(m2));
            chk("spawn_pos", 64'({bullet_x, bullet_y} & {pos_mask(m2), pos_mask(m2)}),
                64'({m_xs(), m_ys()} & {pos_mask(m2), pos_mask(m2)}));
        end
    endtask

    task automatic do_tick(input bit chk_tile, input int etx, input int ety);
        cyc(1);
        model_sweep();
        game_tick = 1'b1;
        cyc(1);
        game_tick = 1'b0;
        cyc(1);
        @(negedge clk) if (chk_tile) begin
            chk("tile_x", 64'(tile_x), 64'(etx));
            chk("tile_y", 64'(tile_y), 64'(ety));
        end
        cyc(14);
        @(negedge clk) chk("post_sweep_valid", 64'(bullet_valid), 64'(m_mask()));
    endtask

    task automatic set_tanks(input int xa, input int ya, input bit aa,
                             input int xb, input int yb, input bit ab);
        tank_xa = 8'(xa); tank_ya = 8'(ya); alive_a = aa;
        tank_xb = 8'(xb); tank_yb = 8'(yb); alive_b = ab;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        map_clear();
        model_clear();
        cyc(3);
        rst = 1'b0;
        @(negedge clk) begin
            chk("reset_ctrl", 64'({hit_a, hit_b, busy, tile_x, tile_y, bullet_valid}), 64'd0);
            chk("reset_pos", 64'({bullet_x, bullet_y}), 64'd0);
        end

        // Basic spawn and move
        set_tanks(10, 10, 1, 150, 10, 1);
        fire(1, 0, 100, 72, 3, 0, 0, 0);
        do_tick(0, 0, 0);

        // Wall hit at tile (3,4)
        do_reset();
        m_map[4][3] = 2'd1;
        fire(1, 0, 30, 40, 0, 0, 0, 0);
        do_tick(1, 3, 4);

        // Hit on tank B, then the same shot with B dead
        do_reset();
        set_tanks(10, 10, 1, 64, 68, 1);
        fire(1, 0, 60, 72, 3, 0, 0, 0);
        do_tick(0, 0, 0);
        do_tick(0, 0, 0);
        alive_b = 1'b0;
        fire(1, 0, 60, 72, 3, 0, 0, 0);
        do_tick(0, 0, 0);
        do_tick(0, 0, 0);
        do_tick(0, 0, 0);

        // Owner immunity plus simultaneous fire; B's shot does hit A
        do_reset();
        set_tanks(64, 68, 1, 150, 20, 1);
        fire(1, 1, 60, 72, 3, 66, 80, 0);
        for (int k = 0; k < 4; k++) do_tick(0, 0, 0);

        // Boundaries and full pool
        do_reset();
        set_tanks(100, 100, 1, 120, 100, 1);
        fire(1, 0, 198, 10, 3, 0, 0, 0);
        fire(0, 1, 0, 0, 0, 1, 20, 2);
        fire(1, 0, 10, 141, 1, 0, 0, 0);
        fire(0, 1, 0, 0, 0, 10, 143, 1);
        fire(0, 1, 0, 0, 0, 50, 50, 0);
        do_tick(0, 0, 0);
        fire(1, 1, 197, 30, 3, 10, 2, 0);
        do_tick(0, 0, 0);
        do_tick(0, 0, 0);

        // Tick while busy: one extra sweep right after DONE, further ticks lost
        do_reset();
        set_tanks(100, 100, 1, 120, 100, 1);
        fire(1, 0, 20, 20, 3, 0, 0, 0);
        cyc(1);
        model_sweep();
        game_tick = 1'b1; cyc(1); game_tick = 1'b0;
        cyc(4);
        game_tick = 1'b1; cyc(1); game_tick = 1'b0;
        cyc(1);
        game_tick = 1'b1; cyc(1); game_tick = 1'b0;
        model_sweep();
        cyc(6);
        @(negedge clk) chk("gap_idle", 64'(busy), 64'd0);
        cyc(1);
        @(negedge clk) chk("restart_busy", 64'(busy), 64'd1);
        cyc(16);
        @(negedge clk) chk("double_valid", 64'(bullet_valid), 64'(m_mask()));

        // Fire arriving mid-sweep is served afterwards
        cyc(1);
        model_sweep();
        game_tick = 1'b1; cyc(1); game_tick = 1'b0;
        cyc(3);
        fire_b = 1'b1; start_xb = 8'd40; start_yb = 8'd50; dir_b = 2'd1;
        model_spawn(1, 40, 50, 1);
        cyc(1); fire_b = 1'b0;
        cyc(2);
        @(negedge clk) chk("mid_fire_held", 64'(bullet_valid), 64'(4'b0001 & m_mask()));
        cyc(12);
        @(negedge clk) chk("mid_fire_served", 64'(bullet_valid), 64'(m_mask()));

        // Reset in the middle of a sweep
        do_reset();
        set_tanks(10, 10, 1, 64, 68, 1);
        fire(1, 0, 20, 20, 3, 0, 0, 0);
        fire(1, 0, 40, 40, 1, 0, 0, 0);
        fire(1, 0, 62, 72, 3, 0, 0, 0);
        cyc(1);
        game_tick = 1'b1; cyc(1); game_tick = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk) begin
            chk("abort_ctrl", 64'({hit_a, hit_b, busy, tile_x, tile_y, bullet_valid}), 64'd0);
            chk("abort_pos", 64'({bullet_x, bullet_y}), 64'd0);
        end
        model_clear();
        cyc(20);

        // Randomized play
        do_reset();
        for (int it = 0; it < 30; it++) begin
            int r;
            set_tanks($urandom_range(0, 192), $urandom_range(0, 136), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 192), $urandom_range(0, 136), 1'($urandom_range(0, 1)));
            map_clear();
            for (int w = 0; w < 10; w++)
                m_map[$urandom_range(0, 17)][$urandom_range(0, 24)] = 2'($urandom_range(1, 3));
            r = $urandom_range(0, 3);
            if (r != 0)
                fire(r[0], r[1],
                     $urandom_range(0, MAX_X), $urandom_range(0, MAX_Y), $urandom_range(0, 3),
                     $urandom_range(0, MAX_X), $urandom_range(0, MAX_Y), $urandom_range(0, 3));
            repeat ($urandom_range(1, 2)) do_tick(0, 0, 0);
        end

        cyc(20);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
